// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write controller bridging request/stream handshakes to a simple memory port
// Ports:
//   clk, rst                              clock and synchronous active-high reset
//   req_valid/req_ready/req_wr/addr/len   burst request (len = beats minus one)
//   wdata_valid/wdata_ready/wdata_in      write-beat stream into the controller
//   rsp_valid/rsp_ready/rsp_data          read-beat stream out of the controller
//   done                                  one-cycle pulse after the final beat
//   mem_addr/mem_wdata/mem_wr_en/mem_rd_en/mem_rdata  memory port (read data one cycle after mem_rd_en)
module mem_burst_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, RSP, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]  beats_left_q, beats_left_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cur_addr_q   <= '0;
            beats_left_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            beats_left_q <= beats_left_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        beats_left_d = beats_left_q;
        rsp_data_d   = rsp_data_q;
        case (state_q)
            IDLE: if (req_valid) begin
                cur_addr_d   = req_addr;
                beats_left_d = req_len;
                state_d      = req_wr ? WR : RD;
            end
            WR: if (wdata_valid) begin
                if (beats_left_q == '0) state_d = DONE;
                else begin
                    cur_addr_d   = cur_addr_q + ADDR_W'(1);
                    beats_left_d = beats_left_q - LEN_W'(1);
                end
            end
            RD: state_d = RD_CAP;
            RD_CAP: begin
                rsp_data_d = mem_rdata;
                state_d    = RSP;
            end
            RSP: if (rsp_ready) begin
                if (beats_left_q == '0) state_d = DONE;
                else begin
                    cur_addr_d   = cur_addr_q + ADDR_W'(1);
                    beats_left_d = beats_left_q - LEN_W'(1);
                    state_d      = RD;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = state_q == IDLE;
    assign wdata_ready = state_q == WR;
    assign mem_wr_en   = (state_q == WR) && wdata_valid;
    assign mem_rd_en   = state_q == RD;
    assign mem_addr    = cur_addr_q;
    assign mem_wdata   = (state_q == WR) ? wdata_in : '0;
    assign rsp_valid   = state_q == RSP;
    assign rsp_data    = rsp_data_q;
    assign done        = state_q == DONE;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized self-checking bench against a burst-level memory model
module tb_mem_burst_ctrl;
    logic       clk = 1'b0;
    logic       rst, req_valid, req_ready, req_wr;
    logic [6:0] req_addr, mem_addr;
    logic [3:0] req_len;
    logic       wdata_valid, wdata_ready, rsp_valid, rsp_ready, done, mem_wr_en, mem_rd_en;
    logic [7:0] wdata_in, rsp_data, mem_wdata, mem_rdata;
    logic       init;
    logic [7:0] tb_mem [128];
    logic [7:0] ref_mem [128];
    logic [7:0] wd [16];
    int         n_chk = 0, n_pass = 0;

    mem_burst_ctrl #(.ADDR_W(7), .DATA_W(8), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata_in(wdata_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .done(done), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (init) for (int i = 0; i < 128; i++) tb_mem[i] <= 8'(i * 37 + 5);
        else if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        #2;
        if (!rst && !init) begin
            chk("strobe_excl", 32'(mem_wr_en & mem_rd_en), 0);
            chk("rd_while_rsp", 32'(mem_rd_en & rsp_valid), 0);
        end
    end

    task automatic do_write(input logic [6:0] a, input int len, input int gap_at, input int gap_n);
        logic [6:0] ea;
        @(negedge clk);
        chk("wr_req_ready", 32'(req_ready), 1);
        req_valid = 1; req_wr = 1; req_addr = a; req_len = 4'(len);
        @(negedge clk);
        req_valid = 0; req_addr = $urandom; req_len = $urandom;
        for (int i = 0; i <= len; i++) begin
            ea = a + 7'(i);
            if (i == gap_at) repeat (gap_n) begin
                wdata_valid = 0; wdata_in = $urandom;
                #1 chk("gap_wr_en", 32'(mem_wr_en), 0);
                chk("gap_addr", 32'(mem_addr), 32'(ea));
                chk("gap_wdata_ready", 32'(wdata_ready), 1);
                @(negedge clk);
            end
            wdata_valid = 1; wdata_in = wd[i];
            #1 chk("wr_en", 32'(mem_wr_en), 1);
            chk("wr_addr", 32'(mem_addr), 32'(ea));
            chk("wr_data", 32'(mem_wdata), 32'(wd[i]));
            chk("wr_done_early", 32'(done), 0);
            ref_mem[ea] = wd[i];
            @(negedge clk);
        end
        wdata_valid = 0;
        #1 chk("wr_done", 32'(done), 1);
        chk("wr_done_ready", 32'(req_ready), 0);
        chk("wr_done_strobe", 32'(mem_wr_en), 0);
        @(negedge clk);
        #1 chk("wr_done_pulse", 32'(done), 0);
        chk("wr_idle_ready", 32'(req_ready), 1);
        for (int i = 0; i <= len; i++) chk("wr_mem", 32'(tb_mem[a + 7'(i)]), 32'(ref_mem[a + 7'(i)]));
    endtask

    task automatic do_read(input logic [6:0] a, input int len, input int bp_at, input int bp_n);
        logic [6:0] ea;
        @(negedge clk);
        chk("rd_req_ready", 32'(req_ready), 1);
        req_valid = 1; req_wr = 0; req_addr = a; req_len = 4'(len);
        @(negedge clk);
        req_valid = 0; req_addr = $urandom; req_len = $urandom;
        for (int i = 0; i <= len; i++) begin
            ea = a + 7'(i);
            rsp_ready = 1'($urandom);
            wdata_valid = 1'($urandom); wdata_in = $urandom;
            #1 chk("rd_en", 32'(mem_rd_en), 1);
            chk("rd_addr", 32'(mem_addr), 32'(ea));
            chk("rd_no_wr", 32'(mem_wr_en), 0);
            chk("rd_rsp_valid", 32'(rsp_valid), 0);
            @(negedge clk);
            #1 chk("cap_rd_en", 32'(mem_rd_en), 0);
            chk("cap_rsp_valid", 32'(rsp_valid), 0);
            @(negedge clk);
            if (i == bp_at) repeat (bp_n) begin
                rsp_ready = 0;
                #1 chk("bp_valid", 32'(rsp_valid), 1);
                chk("bp_data", 32'(rsp_data), 32'(ref_mem[ea]));
                chk("bp_rd_en", 32'(mem_rd_en), 0);
                @(negedge clk);
            end
            rsp_ready = 1;
            #1 chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_data", 32'(rsp_data), 32'(ref_mem[ea]));
            chk("rsp_done_early", 32'(done), 0);
            @(negedge clk);
        end
        rsp_ready = 0; wdata_valid = 0;
        #1 chk("rd_done", 32'(done), 1);
        chk("rd_done_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        #1 chk("rd_done_pulse", 32'(done), 0);
        chk("rd_idle_ready", 32'(req_ready), 1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i * 37 + 5);
        rst = 1; init = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_len = 0;
        wdata_valid = 0; wdata_in = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        init = 0;
        #1 chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_strobes", 32'({mem_wr_en, mem_rd_en}), 0);
        chk("rst_wdata_ready", 32'(wdata_ready), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        rst = 0;
        @(negedge clk);
        #1 chk("rst_req_ready", 32'(req_ready), 1);

        for (int i = 0; i < 4; i++) wd[i] = 8'hA0 + 8'(i);
        do_write(7'h10, 3, -1, 0);
        do_read(7'h10, 3, -1, 0);
        for (int i = 0; i < 4; i++) wd[i] = 8'hC0 + 8'(i);
        do_write(7'h7E, 3, -1, 0);
        do_read(7'h7E, 3, -1, 0);
        for (int i = 0; i < 6; i++) wd[i] = 8'($urandom);
        do_write(7'h30, 5, 2, 3);
        do_read(7'h30, 5, 1, 5);

        @(negedge clk);
        req_valid = 1; req_wr = 0; req_addr = 7'h20; req_len = 3;
        @(negedge clk);
        req_valid = 0; rsp_ready = 1;
        repeat (3) @(negedge clk);
        #1 chk("mid_rd_en", 32'(mem_rd_en), 1);
        rst = 1;
        @(negedge clk);
        #1 chk("mid_rst_strobes", 32'({mem_wr_en, mem_rd_en}), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_wdata_ready", 32'(wdata_ready), 0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 0);
        rst = 0; rsp_ready = 0;
        repeat (4) begin
            @(negedge clk);
            #1 chk("post_rst_ready", 32'(req_ready), 1);
            chk("post_rst_done", 32'(done), 0);
            chk("post_rst_rd_en", 32'(mem_rd_en), 0);
        end

        for (int k = 0; k < 40; k++) begin
            logic [6:0] a;
            int len;
            a = 7'($urandom_range(0, 127));
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) wd[i] = 8'($urandom);
                do_write(a, len, $urandom_range(0, 15), $urandom_range(0, 3));
            end else do_read(a, len, $urandom_range(0, 15), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
